// File: rtl/i2c_target_regs.sv
// I2C target with an internal byte-wide register file. SCL/SDA are synchronized,
// glitch-filtered and decoded in the clk domain; SDA is driven open-drain via sda_oe.
module i2c_target_regs #(
  parameter logic [6:0] DEV_ADDR   = 7'h42,
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        scl_in,
  input  logic                        sda_in,
  output logic                        sda_oe,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_addr,
  output logic [7:0]                  wr_data,
  output logic [8*NUM_REGS-1:0]       regs_flat,
  output logic                        busy
);

  localparam int         AW       = $clog2(NUM_REGS);
  localparam logic [3:0] FCNT_MAX = 4'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_PTR,
    ST_WRITE,
    ST_READ,
    ST_IGNORE
  } state_t;

  // Bit 0 carries SCL, bit 1 carries SDA through the conditioning chain.
  logic [1:0]      sync1_d, sync1_q;
  logic [1:0]      sync2_d, sync2_q;
  logic [1:0]      filt_d, filt_q;
  logic [1:0]      prev_d, prev_q;
  logic [1:0][3:0] fcnt_d, fcnt_q;

  state_t          state_d, state_q;
  logic [3:0]      bit_cnt_d, bit_cnt_q;
  logic [7:0]      shift_d, shift_q;
  logic [AW-1:0]   ptr_d, ptr_q;
  logic            rw_d, rw_q;
  logic            sda_oe_d, sda_oe_q;
  logic            busy_d, busy_q;
  logic            wr_strobe_d, wr_strobe_q;
  logic [AW-1:0]   wr_addr_d, wr_addr_q;
  logic [7:0]      wr_data_d, wr_data_q;
  logic [7:0]      regs_d [NUM_REGS];
  logic [7:0]      regs_q [NUM_REGS];

  logic            scl_f, sda_f;
  logic            scl_rise, scl_fall;
  logic            start_evt, stop_evt;
  logic [7:0]      rx_byte;
  logic [7:0]      rd_byte;

  always_comb begin
    sync1_d = {sda_in, scl_in};
    sync2_d = sync1_q;
    prev_d  = filt_q;
    filt_d  = filt_q;
    for (int i = 0; i < 2; i++) begin
      fcnt_d[i] = 4'd0;
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == FCNT_MAX) begin
          filt_d[i] = sync2_q[i];
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_rise = scl_f & ~prev_q[0];
  assign scl_fall = ~scl_f & prev_q[0];
  // SDA edges only count as bus events while SCL was and still is high.
  assign start_evt = scl_f & prev_q[0] & prev_q[1] & ~sda_f;
  assign stop_evt  = scl_f & prev_q[0] & ~prev_q[1] & sda_f;
  assign rx_byte   = {shift_q[6:0], sda_f};
  assign rd_byte   = regs_q[ptr_q];

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_oe_d    = sda_oe_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    regs_d      = regs_q;

    if (start_evt) begin
      state_d   = ST_ADDR;
      bit_cnt_d = 4'd0;
      sda_oe_d  = 1'b0;
    end else if (stop_evt) begin
      state_d  = ST_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WRITE: begin
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              shift_d   = rx_byte;
              bit_cnt_d = bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7 && state_q == ST_PTR) begin
                ptr_d = rx_byte[AW-1:0];
              end
              if (bit_cnt_q == 4'd7 && state_q == ST_WRITE) begin
                regs_d[ptr_q] = rx_byte;
                wr_strobe_d   = 1'b1;
                wr_addr_d     = ptr_q;
                wr_data_d     = rx_byte;
                ptr_d         = ptr_q + 1'b1;
              end
            end else if (bit_cnt_q == 4'd8) begin
              bit_cnt_d = 4'd9;
            end
          end else if (scl_fall) begin
            if (bit_cnt_q == 4'd8) begin
              if (state_q != ST_ADDR || shift_q[7:1] == DEV_ADDR) begin
                sda_oe_d = 1'b1;
                if (state_q == ST_ADDR) begin
                  busy_d = 1'b1;
                  rw_d   = shift_q[0];
                end
              end else begin
                state_d  = ST_IGNORE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end
            end else if (bit_cnt_q == 4'd9) begin
              // End of the ACK slot: release SDA, or start driving the first read byte.
              sda_oe_d  = 1'b0;
              bit_cnt_d = 4'd0;
              if (state_q == ST_ADDR && rw_q) begin
                state_d  = ST_READ;
                shift_d  = rd_byte;
                sda_oe_d = ~rd_byte[7];
                ptr_d    = ptr_q + 1'b1;
              end else if (state_q == ST_ADDR) begin
                state_d = ST_PTR;
              end else begin
                state_d = ST_WRITE;
              end
            end
          end
        end
        ST_READ: begin
          if (scl_rise) begin
            if (bit_cnt_q < 4'd8) begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else if (bit_cnt_q == 4'd8) begin
              if (sda_f) begin
                state_d  = ST_IGNORE;
                sda_oe_d = 1'b0;
                busy_d   = 1'b0;
              end else begin
                bit_cnt_d = 4'd9;
              end
            end
          end else if (scl_fall) begin
            if (bit_cnt_q >= 4'd1 && bit_cnt_q <= 4'd7) begin
              shift_d  = {shift_q[6:0], 1'b0};
              sda_oe_d = ~shift_q[6];
            end else if (bit_cnt_q == 4'd8) begin
              sda_oe_d = 1'b0;
            end else if (bit_cnt_q == 4'd9) begin
              bit_cnt_d = 4'd0;
              shift_d   = rd_byte;
              sda_oe_d  = ~rd_byte[7];
              ptr_d     = ptr_q + 1'b1;
            end
          end
        end
        default: begin
          sda_oe_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      prev_q      <= 2'b11;
      fcnt_q      <= '0;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 4'd0;
      shift_q     <= 8'd0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_oe_q    <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 8'd0;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= 8'd0;
      end
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      filt_q      <= filt_d;
      prev_q      <= prev_d;
      fcnt_q      <= fcnt_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_oe_q    <= sda_oe_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      for (int k = 0; k < NUM_REGS; k++) begin
        regs_q[k] <= regs_d[k];
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      regs_flat[8*k +: 8] = regs_q[k];
    end
  end

  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_addr   = wr_addr_q;
  assign wr_data   = wr_data_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: a bit-banged I2C master on a wired-AND bus, checked
// against a transaction-level register/pointer model.
`timescale 1ns/1ps
module tb_i2c_target_regs;

  localparam int N = 16;
  localparam int Q = 10;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           scl_m = 1'b1;
  logic           sda_m = 1'b1;
  logic           scl_in, sda_in;
  logic           sda_oe, wr_strobe, busy;
  logic [3:0]     wr_addr;
  logic [7:0]     wr_data;
  logic [8*N-1:0] regs_flat;

  int             n_chk = 0;
  int             n_err = 0;
  int             oe_cnt = 0;
  int             busy_cnt = 0;
  int             strobe_n = 0;
  logic [7:0]     log_a [1024];
  logic [7:0]     log_d [1024];

  logic [7:0]     mregs [N];
  int             mptr;
  logic [7:0]     wdata [8];

  always #20 clk = ~clk;

  assign scl_in = scl_m;
  assign sda_in = sda_m & ~sda_oe;

  i2c_target_regs #(.DEV_ADDR(7'h42), .NUM_REGS(N), .FILTER_LEN(4)) dut (
    .clk(clk), .rst(rst), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
    .regs_flat(regs_flat), .busy(busy)
  );

  always @(negedge clk) begin
    if (sda_oe) oe_cnt <= oe_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
    if (wr_strobe && strobe_n < 1024) begin
      log_a[strobe_n] <= 8'(wr_addr);
      log_d[strobe_n] <= wr_data;
      strobe_n        <= strobe_n + 1;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // mode 1: short SCL low glitch in the high phase; mode 2: short SDA glitch in the high phase.
  task automatic bit_out(input logic b, input int mode);
    sda_m = b; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    if (mode == 1) begin
      scl_m = 1'b0; wclk(2); scl_m = 1'b1; wclk(Q - 2);
    end else if (mode == 2) begin
      sda_m = ~b; wclk(2); sda_m = b; wclk(Q - 2);
    end else begin
      wclk(Q);
    end
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bit_in(output logic b);
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    b = sda_in; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic byte_out(input logic [7:0] d, input int mode, output logic ack_n);
    for (int i = 7; i >= 0; i--) bit_out(d[i], (i == 3) ? mode : 0);
    bit_in(ack_n);
  endtask

  task automatic byte_in(input logic nack, output logic [7:0] d);
    logic b;
    d = 8'd0;
    for (int i = 7; i >= 0; i--) begin
      bit_in(b);
      d[i] = b;
    end
    bit_out(nack, 0);
  endtask

  task automatic bus_start;
    sda_m = 1'b1; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b0; wclk(Q);
  endtask

  task automatic bus_stop;
    sda_m = 1'b0; wclk(Q);
    scl_m = 1'b1; wclk(Q);
    sda_m = 1'b1; wclk(Q);
  endtask

  task automatic do_write(input logic [7:0] p, input int n, input int gmode);
    logic       a;
    int         base;
    logic [7:0] exp_a [8];
    base = strobe_n;
    bus_start;
    byte_out(8'h84, 0, a); chk("wr_addr_ack", a, 0);
    chk("busy_on", busy, 1);
    byte_out(p, 0, a); chk("ptr_ack", a, 0);
    mptr = int'(p) % N;
    for (int i = 0; i < n; i++) begin
      byte_out(wdata[i], gmode, a); chk("data_ack", a, 0);
      exp_a[i] = 8'(mptr);
      mregs[mptr] = wdata[i];
      mptr = (mptr + 1) % N;
    end
    bus_stop;
    chk("busy_off", busy, 0);
    chk("strobe_cnt", strobe_n - base, n);
    for (int i = 0; i < n && base + i < strobe_n; i++) begin
      chk("strobe_addr", log_a[base + i], exp_a[i]);
      chk("strobe_data", log_d[base + i], wdata[i]);
    end
  endtask

  task automatic do_read(input logic setp, input logic [7:0] p, input int n);
    logic       a;
    logic [7:0] d;
    bus_start;
    if (setp) begin
      byte_out(8'h84, 0, a); chk("rd_wr_ack", a, 0);
      byte_out(p, 0, a); chk("rd_ptr_ack", a, 0);
      mptr = int'(p) % N;
      bus_start;
    end
    byte_out(8'h85, 0, a); chk("rd_addr_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      byte_in(i == n - 1, d);
      chk("rd_data", d, mregs[mptr]);
      mptr = (mptr + 1) % N;
    end
    chk("rel_after_nack", sda_oe, 0);
    bus_stop;
    chk("rd_busy_off", busy, 0);
  endtask

  initial begin
    logic a;
    int   oe0, b0, s0;
    for (int k = 0; k < N; k++) mregs[k] = 8'd0;
    mptr = 0;

    wclk(3);
    chk("rst_oe", sda_oe, 0);
    chk("rst_strobe", wr_strobe, 0);
    rst = 1'b0;
    wclk(10);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_regs", |regs_flat, 0);

    // Write burst
    wdata[0] = 8'hA5; wdata[1] = 8'h5A; wdata[2] = 8'h3C;
    do_write(8'h02, 3, 0);
    chk("burst_r2", regs_flat[23:16], 8'hA5);
    chk("burst_r3", regs_flat[31:24], 8'h5A);
    chk("burst_r4", regs_flat[39:32], 8'h3C);

    // Random read via repeated START
    do_read(1'b1, 8'h03, 2);

    // Wrong address
    oe0 = oe_cnt; b0 = busy_cnt; s0 = strobe_n;
    bus_start;
    byte_out(8'h90, 0, a); chk("bad_addr_nack", a, 1);
    byte_out(8'h01, 0, a);
    byte_out(8'hEE, 0, a);
    bus_stop;
    chk("bad_no_oe", oe_cnt - oe0, 0);
    chk("bad_no_busy", busy_cnt - b0, 0);
    chk("bad_no_strobe", strobe_n - s0, 0);
    do_read(1'b1, 8'h02, 1);

    // Pointer wrap and out-of-range pointer
    wdata[0] = 8'h11; wdata[1] = 8'h22;
    do_write(8'h0F, 2, 0);
    chk("wrap_r15", regs_flat[127:120], 8'h11);
    chk("wrap_r0", regs_flat[7:0], 8'h22);
    wdata[0] = 8'h77;
    do_write(8'h1F, 1, 0);
    chk("oor_r15", regs_flat[127:120], 8'h77);

    // Glitch rejection on SCL and on SDA (false START and false STOP attempts)
    wdata[0] = 8'hC9;
    do_write(8'h06, 1, 1);
    chk("glitch_scl_r6", regs_flat[55:48], 8'hC9);
    wdata[0] = 8'h08; wdata[1] = 8'hF0;
    do_write(8'h07, 2, 2);
    chk("glitch_sda_r7", regs_flat[63:56], 8'h08);
    chk("glitch_sda_r8", regs_flat[71:64], 8'hF0);

    // Randomized transactions
    for (int t = 0; t < 14; t++) begin
      int r, n;
      r = $urandom_range(0, 2);
      if (r == 0) begin
        n = $urandom_range(1, 4);
        for (int i = 0; i < n; i++) wdata[i] = 8'($urandom);
        do_write(8'($urandom), n, 0);
      end else begin
        n = $urandom_range(1, 3);
        do_read(r == 1, 8'($urandom), n);
      end
    end

    // Reset while the target drives a 0 data bit
    wdata[0] = 8'h3C;
    do_write(8'h09, 1, 0);
    bus_start;
    byte_out(8'h84, 0, a);
    byte_out(8'h09, 0, a);
    bus_start;
    byte_out(8'h85, 0, a); chk("rr_addr_ack", a, 0);
    chk("rr_drive_zero", sda_oe, 1);
    rst = 1'b1;
    wclk(1);
    chk("rr_oe_rel", sda_oe, 0);
    chk("rr_regs_zero", |regs_flat, 0);
    chk("rr_busy", busy, 0);
    wclk(3);
    rst = 1'b0;
    wclk(Q);
    bus_stop;
    for (int k = 0; k < N; k++) mregs[k] = 8'd0;
    mptr = 0;
    wdata[0] = 8'h96; wdata[1] = 8'h4B;
    do_write(8'h0A, 2, 0);
    do_read(1'b1, 8'h0A, 2);

    for (int k = 0; k < N; k++) chk("final_reg", regs_flat[8*k +: 8], mregs[k]);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
